// File: rtl/id_ex_stage.sv
// ID->EX pipeline register: operand forwarding from EX/MEM,
// load-use bubble insertion, downstream hold and squash.
module id_ex_stage #(
   parameter int DW = 32,
   parameter int RW = 5,
   parameter int AW = 4
) (
   input  logic          clock,
   input  logic          resetn,
   input  logic [DW-1:0] d_qa,
   input  logic [DW-1:0] d_qb,
   input  logic [DW-1:0] d_imm,
   input  logic [4:0]    d_sa,
   input  logic [RW-1:0] d_rs,
   input  logic [RW-1:0] d_rt,
   input  logic          d_use_rs,
   input  logic          d_use_rt,
   input  logic [RW-1:0] d_rn,
   input  logic [AW-1:0] d_aluc,
   input  logic          d_shift,
   input  logic          d_aluimm,
   input  logic          d_wreg,
   input  logic          d_m2reg,
   input  logic          d_wmem,
   input  logic          d_valid,
   input  logic [DW-1:0] e_r,
   input  logic [DW-1:0] m_r,
   input  logic [DW-1:0] m_mo,
   input  logic [RW-1:0] m_rn,
   input  logic          m_wreg,
   input  logic          m_m2reg,
   input  logic          hold,
   input  logic          squash,
   output logic [DW-1:0] e_a,
   output logic [DW-1:0] e_b,
   output logic [AW-1:0] e_aluc,
   output logic [DW-1:0] e_sd,
   output logic [RW-1:0] e_rn,
   output logic          e_wreg,
   output logic          e_m2reg,
   output logic          e_wmem,
   output logic          e_valid,
   output logic          stall
);

   typedef struct packed {
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic [DW-1:0] sd;
      logic [AW-1:0] aluc;
      logic [RW-1:0] rn;
      logic          wreg;
      logic          m2reg;
      logic          wmem;
      logic          valid;
   } id_ex_t;

   id_ex_t        ex_q;
   id_ex_t        ex_d;
   logic          ex_alu;
   logic          ex_hit_rs;
   logic          ex_hit_rt;
   logic          mem_hit_rs;
   logic          mem_hit_rt;
   logic [DW-1:0] mem_val;
   logic [DW-1:0] fwd_rs;
   logic [DW-1:0] fwd_rt;
   logic          lu;

   // A load in EX has no data yet, so only ALU results forward from EX
   assign ex_alu     = ex_q.wreg & ~ex_q.m2reg;
   assign mem_val    = m_m2reg ? m_mo : m_r;

   assign ex_hit_rs  = ex_alu & (d_rs != '0)
                     & (ex_q.rn == d_rs);
   assign ex_hit_rt  = ex_alu & (d_rt != '0)
                     & (ex_q.rn == d_rt);
   assign mem_hit_rs = ~ex_hit_rs & m_wreg
                     & (d_rs != '0) & (m_rn == d_rs);
   assign mem_hit_rt = ~ex_hit_rt & m_wreg
                     & (d_rt != '0) & (m_rn == d_rt);

   always_comb begin
      fwd_rs = d_qa;
      unique case (1'b1)
         ex_hit_rs:  fwd_rs = e_r;
         mem_hit_rs: fwd_rs = mem_val;
         default:    fwd_rs = d_qa;
      endcase
   end

   always_comb begin
      fwd_rt = d_qb;
      unique case (1'b1)
         ex_hit_rt:  fwd_rt = e_r;
         mem_hit_rt: fwd_rt = mem_val;
         default:    fwd_rt = d_qb;
      endcase
   end

   assign lu = d_valid & ex_q.valid & ex_q.wreg
             & ex_q.m2reg & (ex_q.rn != '0)
             & ((d_use_rs & (d_rs == ex_q.rn))
             |  (d_use_rt & (d_rt == ex_q.rn)));

   assign stall = lu | hold;

   always_comb begin
      ex_d = '0;
      if (!(squash | lu)) begin
         ex_d.a     = d_shift
                    ? {{(DW-5){1'b0}}, d_sa} : fwd_rs;
         ex_d.b     = d_aluimm ? d_imm : fwd_rt;
         ex_d.sd    = fwd_rt;
         ex_d.aluc  = d_aluc;
         ex_d.rn    = d_rn;
         ex_d.wreg  = d_wreg & d_valid;
         ex_d.m2reg = d_m2reg & d_valid;
         ex_d.wmem  = d_wmem & d_valid;
         ex_d.valid = d_valid;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)
         ex_q <= '0;
      else if (!hold)
         ex_q <= ex_d;
   end

   assign e_a     = ex_q.a;
   assign e_b     = ex_q.b;
   assign e_aluc  = ex_q.aluc;
   assign e_sd    = ex_q.sd;
   assign e_rn    = ex_q.rn;
   assign e_wreg  = ex_q.wreg;
   assign e_m2reg = ex_q.m2reg;
   assign e_wmem  = ex_q.wmem;
   assign e_valid = ex_q.valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed hazard scenarios followed
// by randomized traffic against a behavioural EX model.
module tb_id_ex_stage;

   logic        clock = 1'b0;
   logic        resetn;
   logic [31:0] d_qa, d_qb, d_imm;
   logic [4:0]  d_sa, d_rs, d_rt, d_rn;
   logic        d_use_rs, d_use_rt;
   logic [3:0]  d_aluc;
   logic        d_shift, d_aluimm, d_wreg, d_m2reg;
   logic        d_wmem, d_valid;
   logic [31:0] e_r, m_r, m_mo;
   logic [4:0]  m_rn;
   logic        m_wreg, m_m2reg, hold, squash;
   logic [31:0] e_a, e_b, e_sd;
   logic [3:0]  e_aluc;
   logic [4:0]  e_rn;
   logic        e_wreg, e_m2reg, e_wmem, e_valid, stall;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] sd;
      logic [3:0]  aluc;
      logic [4:0]  rn;
      logic        wreg;
      logic        m2reg;
      logic        wmem;
      logic        valid;
   } ex_t;

   ex_t mex;

   always #5 clock = ~clock;

   id_ex_stage dut (
      .clock(clock), .resetn(resetn),
      .d_qa(d_qa), .d_qb(d_qb), .d_imm(d_imm),
      .d_sa(d_sa), .d_rs(d_rs), .d_rt(d_rt),
      .d_use_rs(d_use_rs), .d_use_rt(d_use_rt),
      .d_rn(d_rn), .d_aluc(d_aluc),
      .d_shift(d_shift), .d_aluimm(d_aluimm),
      .d_wreg(d_wreg), .d_m2reg(d_m2reg),
      .d_wmem(d_wmem), .d_valid(d_valid),
      .e_r(e_r), .m_r(m_r), .m_mo(m_mo),
      .m_rn(m_rn), .m_wreg(m_wreg),
      .m_m2reg(m_m2reg), .hold(hold),
      .squash(squash),
      .e_a(e_a), .e_b(e_b), .e_aluc(e_aluc),
      .e_sd(e_sd), .e_rn(e_rn), .e_wreg(e_wreg),
      .e_m2reg(e_m2reg), .e_wmem(e_wmem),
      .e_valid(e_valid), .stall(stall)
   );

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h",
                tag, obs, exp);
      end
   endtask

   // value a source register reads after forwarding
   function automatic logic [31:0] src_val(
      input logic [4:0] src, input logic [31:0] q);
      if (src == 0) return q;
      if (mex.wreg && !mex.m2reg && mex.rn == src)
         return e_r;
      if (m_wreg && m_rn == src)
         return m_m2reg ? m_mo : m_r;
      return q;
   endfunction

   function automatic bit model_lu();
      bit dep;
      dep = (d_use_rs && d_rs == mex.rn)
         || (d_use_rt && d_rt == mex.rn);
      return d_valid && mex.valid && mex.wreg
          && mex.m2reg && mex.rn != 0 && dep;
   endfunction

   function automatic ex_t model_next();
      ex_t n;
      if (hold) return mex;
      n = '0;
      if (squash || model_lu()) return n;
      n.a     = d_shift ? 32'(d_sa) : src_val(d_rs, d_qa);
      n.b     = d_aluimm ? d_imm : src_val(d_rt, d_qb);
      n.sd    = src_val(d_rt, d_qb);
      n.aluc  = d_aluc;
      n.rn    = d_rn;
      n.valid = d_valid;
      n.wreg  = d_valid && d_wreg;
      n.m2reg = d_valid && d_m2reg;
      n.wmem  = d_valid && d_wmem;
      return n;
   endfunction

   task automatic check_all();
      chk("e_a", e_a, mex.a);
      chk("e_b", e_b, mex.b);
      chk("e_sd", e_sd, mex.sd);
      chk("e_aluc", 32'(e_aluc), 32'(mex.aluc));
      chk("e_rn", 32'(e_rn), 32'(mex.rn));
      chk("e_wreg", 32'(e_wreg), 32'(mex.wreg));
      chk("e_m2reg", 32'(e_m2reg), 32'(mex.m2reg));
      chk("e_wmem", 32'(e_wmem), 32'(mex.wmem));
      chk("e_valid", 32'(e_valid), 32'(mex.valid));
   endtask

   // entered 1 time unit after a rising edge
   task automatic cycle();
      ex_t nx;
      #1;
      chk("stall", 32'(stall), 32'(model_lu() || hold));
      nx = model_next();
      @(posedge clock);
      #1;
      mex = nx;
      check_all();
   endtask

   task automatic idle();
      d_qa = 0; d_qb = 0; d_imm = 0; d_sa = 0;
      d_rs = 0; d_rt = 0; d_rn = 0; d_aluc = 0;
      d_use_rs = 0; d_use_rt = 0;
      d_shift = 0; d_aluimm = 0;
      d_wreg = 0; d_m2reg = 0; d_wmem = 0;
      d_valid = 0;
      e_r = 0; m_r = 0; m_mo = 0; m_rn = 0;
      m_wreg = 0; m_m2reg = 0;
      hold = 0; squash = 0;
   endtask

   task automatic instr(input logic [4:0] rs,
                        input logic [4:0] rt,
                        input logic [4:0] rn,
                        input logic wr,
                        input logic ld);
      d_valid = 1; d_rs = rs; d_rt = rt; d_rn = rn;
      d_use_rs = 1; d_use_rt = 1;
      d_wreg = wr; d_m2reg = ld; d_wmem = 0;
      d_shift = 0; d_aluimm = 0;
   endtask

   task automatic do_reset();
      #3 resetn = 0;
      #1;
      mex = '0;
      check_all();
      chk("rst_stall", 32'(stall), 32'(hold));
      #1 resetn = 1;
   endtask

   initial begin
      ex_t snap;
      idle();
      resetn = 1;
      #2 resetn = 0;
      #1;
      mex = '0;
      check_all();
      chk("reset_stall", 32'(stall), 32'd0);
      #9 resetn = 1;

      // EX forward
      instr(1, 2, 3, 1, 0); d_qa = 32'h1; d_qb = 32'h2;
      cycle();
      instr(3, 6, 7, 1, 0); d_qa = 32'h5;
      e_r = 32'h11;
      cycle();
      chk("ex_fwd", e_a, 32'h11);

      // EX beats MEM
      instr(1, 2, 3, 1, 0);
      cycle();
      instr(3, 6, 8, 1, 0); d_qa = 32'h5;
      e_r = 32'h11; m_r = 32'h22; m_rn = 3; m_wreg = 1;
      cycle();
      chk("ex_over_mem", e_a, 32'h11);

      // r0 never forwards
      instr(1, 2, 0, 1, 0); m_wreg = 0;
      cycle();
      instr(0, 6, 9, 1, 0); d_qa = 32'h1234;
      e_r = 32'h99; m_rn = 0; m_wreg = 1;
      cycle();
      chk("r0_src", e_a, 32'h1234);

      // MEM forward when EX does not match
      instr(10, 11, 12, 1, 0); m_wreg = 0;
      cycle();
      instr(13, 14, 15, 1, 0); d_qb = 32'h7;
      m_rn = 14; m_wreg = 1; m_r = 32'h55;
      cycle();
      chk("mem_fwd", e_b, 32'h55);

      // load-use: one bubble then MEM load data
      instr(1, 2, 4, 1, 1); m_wreg = 0;
      cycle();
      instr(4, 6, 5, 1, 0); d_qa = 32'h5;
      #1 chk("lu_stall", 32'(stall), 32'd1);
      cycle();
      chk("lu_bubble", 32'(e_valid), 32'd0);
      chk("lu_once", 32'(stall), 32'd0);
      m_rn = 4; m_wreg = 1; m_m2reg = 1;
      m_mo = 32'hDEADBEEF; m_r = 32'h1;
      cycle();
      chk("lu_mo_fwd", e_a, 32'hDEADBEEF);
      chk("lu_valid", 32'(e_valid), 32'd1);

      // shift amount and immediate operands
      m_wreg = 0; m_m2reg = 0;
      instr(20, 21, 22, 1, 0); d_shift = 1; d_sa = 7;
      d_qa = 32'hFFFF0000;
      cycle();
      chk("shift_a", e_a, 32'h7);
      instr(23, 24, 25, 1, 0); d_aluimm = 1;
      d_imm = 32'hFFFFFFFC; d_qb = 32'hABCD;
      cycle();
      chk("imm_b", e_b, 32'hFFFFFFFC);
      chk("imm_sd", e_sd, 32'hABCD);

      // hold three cycles with changing inputs
      snap = mex;
      hold = 1;
      for (int i = 0; i < 3; i++) begin
         instr(5'(i + 1), 5'(i + 2), 5'(i + 9), 1, 1);
         d_qa = $urandom; d_qb = $urandom;
         d_wmem = 1;
         cycle();
         chk("hold_frozen", e_a, snap.a);
      end
      #1 chk("hold_stall", 32'(stall), 32'd1);

      // hold beats squash; squash alone is a bubble
      squash = 1;
      cycle();
      chk("hold_squash", 32'(e_valid), 32'(snap.valid));
      hold = 0;
      cycle();
      chk("squash_valid", 32'(e_valid), 32'd0);
      chk("squash_wmem", 32'(e_wmem), 32'd0);
      squash = 0;
      cycle();
      chk("after_squash", 32'(e_wmem), 32'd1);

      // invalid ID instruction clears write controls
      instr(1, 2, 3, 1, 1); d_wmem = 1; d_valid = 0;
      cycle();
      chk("inv_wreg", 32'(e_wreg), 32'd0);

      // async reset while held
      hold = 1; squash = 1;
      do_reset();
      idle();

      // random traffic
      for (int i = 0; i < 600; i++) begin
         d_qa = $urandom; d_qb = $urandom;
         d_imm = $urandom;
         d_sa = 5'($urandom);
         d_rs = 5'($urandom_range(0, 4));
         d_rt = 5'($urandom_range(0, 4));
         d_rn = 5'($urandom_range(0, 4));
         d_use_rs = 1'($urandom);
         d_use_rt = 1'($urandom);
         d_aluc = 4'($urandom);
         d_shift = ($urandom_range(0, 7) == 0);
         d_aluimm = ($urandom_range(0, 3) == 0);
         d_wreg = 1'($urandom);
         d_m2reg = 1'($urandom);
         d_wmem = ($urandom_range(0, 3) == 0);
         d_valid = ($urandom_range(0, 9) != 0);
         e_r = $urandom; m_r = $urandom;
         m_mo = $urandom;
         m_rn = 5'($urandom_range(0, 4));
         m_wreg = 1'($urandom);
         m_m2reg = 1'($urandom);
         hold = ($urandom_range(0, 9) == 0);
         squash = ($urandom_range(0, 9) == 0);
         if (i == 300)
            do_reset();
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed",
               n_tests, n_fail);
      $finish;
   end

endmodule
